// File: rtl/alu_vector_sequencer.sv
// Streams a vector command through a shared external ALU using a two-stage operand/result pipeline.
// Optional build macro ALU_SEQ_OPCHK_EN rejects op 3'b111 as illegal (err pulses with done).
module alu_vector_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_scalar,
  input  logic [31:0]      cmd_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags_acc,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a producer holds its payload until the transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic             scalar_q;
  logic [31:0]      b_q;
  logic             s1_valid;
  logic             s1_last;
  logic             illegal_op;
  logic             cmd_fire;
  logic             in_fire;
  logic             out_fire;
  logic             s1_adv;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign s1_adv      = s1_valid && (!out_valid || out_ready);
  assign in_ready    = (state == RUN) && (issued < len_q) && (!s1_valid || s1_adv);
  assign alu_control = op_q;
  assign dbg_state   = state;

`ifdef ALU_SEQ_OPCHK_EN
  logic err_q;

  assign illegal_op = (cmd_op == 3'b111);
  assign err        = done && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (cmd_fire) begin
      err_q <= illegal_op;
    end
  end
`else
  assign illegal_op = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = ((cmd_len == '0) || illegal_op) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (out_fire && out_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      len_q     <= '0;
      issued    <= '0;
      scalar_q  <= 1'b0;
      b_q       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      flags_acc <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        op_q      <= cmd_op;
        len_q     <= cmd_len;
        scalar_q  <= cmd_scalar;
        b_q       <= cmd_b;
        issued    <= '0;
        flags_acc <= '0;
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        // Stage 1: operands presented to the ALU; the last flag travels with the element.
        if (in_fire) begin
          alu_a   <= in_a;
          alu_b   <= scalar_q ? b_q : in_b;
          s1_last <= (issued == len_q - LEN_W'(1));
          issued  <= issued + LEN_W'(1);
        end
        if (in_fire) begin
          s1_valid <= 1'b1;
        end else if (s1_adv) begin
          s1_valid <= 1'b0;
        end
        // Stage 2: result register, only reloaded when empty or being drained.
        if (s1_adv) begin
          out_data  <= alu_result;
          out_last  <= s1_last;
          flags_acc <= flags_acc | alu_flags;
        end
        if (s1_adv) begin
          out_valid <= 1'b1;
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: behavioural ALU, scoreboard queue, directed and random commands.
// Build with +define+ALU_SEQ_OPCHK_EN to exercise the illegal-op path.
module tb_alu_vector_sequencer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_scalar;
  logic [31:0]      cmd_b;
  logic             in_valid, in_ready;
  logic [31:0]      in_a, in_b;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [2:0]       alu_control;
  logic [3:0]       alu_flags;
  logic             out_valid, out_ready, out_last;
  logic [31:0]      out_data;
  logic             busy, done, err;
  logic [3:0]       flags_acc;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] exp_q[$];
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [3:0]  exp_flags;

  int bp_mode = 0;
  int first_in_cyc, first_out_cyc, last_out_cyc, out_cnt, in_cnt, stall_cnt;
  int acc_cyc, acc_wait, done_cyc, nio_viol;
  logic        watch_nio   = 1'b0;
  logic        hold_chk    = 1'b0;
  logic [32:0] held;
  logic        s1_chk      = 1'b0;
  logic [63:0] s1_exp;
  logic [2:0]  cur_op;
  logic        cur_scalar;
  logic [31:0] cur_b;
  logic        drv_active  = 1'b0;
  logic        abort       = 1'b0;

  alu_vector_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_scalar(cmd_scalar), .cmd_b(cmd_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .flags_acc(flags_acc), .dbg_state(dbg_state)
  );

  // Clock / reset-free clock generation and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: returns {zero, negative, carry, overflow, result}
  function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a * b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = ~(a | b);
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_control, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output backpressure: 0 always ready, 1 toggle every cycle, 2 random
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
      s1_chk   = 1'b0;
    end else begin
      if (hold_chk) check("out_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, held}));
      hold_chk = out_valid && !out_ready;
      held     = {out_last, out_data};
      if (hold_chk) stall_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", 64'({out_last, out_data}), 64'hdead);
        else check("out_elem", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        out_cnt++;
        last_out_cyc = cyc;
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end
      if (s1_chk) begin
        check("s1_operands", {alu_a, alu_b}, s1_exp);
        check("alu_control", 64'(alu_control), 64'(cur_op));
        s1_chk = 1'b0;
      end
      if (in_valid && in_ready) begin
        s1_chk = 1'b1;
        s1_exp = {in_a, cur_scalar ? cur_b : in_b};
        in_cnt++;
        if (first_in_cyc < 0) first_in_cyc = cyc;
      end
      if (watch_nio && (in_ready || out_valid)) nio_viol++;
    end
  end

  task automatic build_expect(input logic [2:0] op, input logic scalar, input logic [31:0] b);
    logic [35:0] r;
    exp_flags = 4'd0;
    for (int i = 0; i < a_q.size(); i++) begin
      r = alu_model(op, a_q[i], scalar ? b : b_q[i]);
      exp_q.push_back({(i == a_q.size() - 1), r[31:0]});
      exp_flags = exp_flags | r[35:32];
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input int len, input logic scalar,
                          input logic [31:0] b);
    @(posedge clk); #1;
    cur_op = op; cur_scalar = scalar; cur_b = b;
    cmd_op = op; cmd_len = LEN_W'(len); cmd_scalar = scalar; cmd_b = b;
    cmd_valid = 1'b1;
    acc_wait = 0;
    do begin @(negedge clk); acc_wait++; end while (!cmd_ready && acc_wait < 100);
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drive_inputs(input int max_gap);
    int gap, budget;
    drv_active = 1'b1;
    while (a_q.size() > 0 && !abort) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; in_a = a_q[0]; in_b = b_q[0];
      budget = 0;
      do begin @(negedge clk); budget++; end while (!in_ready && budget < 500 && !abort);
      if (abort) break;
      if (!in_ready) begin
        check("in_timeout", 64'd1, 64'd0);
        break;
      end
      void'(a_q.pop_front());
      void'(b_q.pop_front());
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    drv_active = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int budget;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!done && budget < 3000);
    check("done_seen", 64'(done), 64'd1);
    check("err", 64'(err), 64'(exp_err));
    check("flags_acc", 64'(flags_acc), 64'(exp_flags));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    done_cyc = cyc;
    @(negedge clk);
    check("done_pulse", 64'({done, cmd_ready, busy}), 64'(3'b010));
    check("flags_hold", 64'(flags_acc), 64'(exp_flags));
  endtask

  task automatic run_cmd(input logic [2:0] op, input int len, input logic scalar,
                         input logic [31:0] b, input int max_gap);
    logic ill;
    ill = 1'b0;
`ifdef ALU_SEQ_OPCHK_EN
    ill = (op == 3'b111);
`endif
    if (ill) begin a_q.delete(); b_q.delete(); end
    exp_q.delete();
    build_expect(op, scalar, b);
    first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    out_cnt = 0; in_cnt = 0; stall_cnt = 0;
    send_cmd(op, len, scalar, b);
    fork
      drive_inputs(max_gap);
      wait_done(ill);
    join
    check("in_count", 64'(in_cnt), ill ? 64'd0 : 64'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_scalar = 1'b0; cmd_b = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({busy, done, err, out_valid, out_last, in_ready}), 64'd0);
    check("rst_data", {alu_a, out_data}, 64'd0);
    check("rst_state", 64'({dbg_state, flags_acc}), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    // add, no backpressure: 11,12,13,14 back to back, latency 2, done next cycle
    bp_mode = 0;
    a_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_q = '{32'd10, 32'd10, 32'd10, 32'd10};
    run_cmd(3'b000, 4, 1'b0, 32'd0, 0);
    check("latency", 64'(first_out_cyc - first_in_cyc), 64'd2);
    check("throughput", 64'(last_out_cyc - first_out_cyc), 64'd3);
    check("done_after_last", 64'(done_cyc - last_out_cyc), 64'd1);

    // multiply under toggling backpressure: 100,35,140 held while stalled
    bp_mode = 1;
    a_q = '{32'd10, 32'd7, 32'd20};
    b_q = '{32'd10, 32'd5, 32'd7};
    run_cmd(3'b100, 3, 1'b0, 32'd0, 0);
    check("stall_seen", 64'(stall_cnt > 0), 64'd1);

    // scalar B = 0 with op 101
    bp_mode = 0;
    a_q = '{32'h000A0A0A, 32'h000A0908};
    b_q = '{32'h12345678, 32'hFFFFFFFF};
    run_cmd(3'b101, 2, 1'b1, 32'd0, 0);

    // zero-length command
    a_q.delete(); b_q.delete();
    nio_viol = 0; watch_nio = 1'b1;
    run_cmd(3'b000, 0, 1'b0, 32'd0, 0);
    watch_nio = 1'b0;
    check("len0_done_cycle", 64'(done_cyc - acc_cyc), 64'd1);
    check("len0_no_io", 64'(nio_viol), 64'd0);

    // reset in the middle of a len-8 subtract
    bp_mode = 0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin a_q.push_back($urandom); b_q.push_back($urandom); end
    build_expect(3'b001, 1'b0, 32'd0);
    out_cnt = 0; first_in_cyc = -1; first_out_cyc = -1;
    send_cmd(3'b001, 8, 1'b0, 32'd0);
    fork
      drive_inputs(0);
    join_none
    budget = 0;
    while (out_cnt < 3 && budget < 100) begin @(negedge clk); budget++; end
    check("outs_before_rst", 64'(out_cnt >= 3), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ab", {alu_a, alu_b}, 64'd0);
    check("rst_mid_data", 64'({alu_control, out_data}), 64'd0);
    check("rst_mid_ctrl", 64'({out_valid, out_last, done, err, busy, flags_acc}), 64'd0);
    abort = 1'b1;
    budget = 0;
    while (drv_active && budget < 10) begin @(negedge clk); budget++; end
    check("driver_stopped", 64'(drv_active), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0;
    a_q = '{32'd2};
    b_q = '{32'd1};
    run_cmd(3'b001, 1, 1'b0, 32'd0, 0);
    check("first_edge_accept", 64'(acc_wait), 64'd1);

    // op 111: illegal with the option, ordinary NOR without it
    a_q.delete(); b_q.delete();
`ifdef ALU_SEQ_OPCHK_EN
    nio_viol = 0; watch_nio = 1'b1;
    run_cmd(3'b111, 5, 1'b0, 32'd0, 0);
    watch_nio = 1'b0;
    check("illegal_done_cycle", 64'(done_cyc - acc_cyc), 64'd1);
    check("illegal_no_io", 64'(nio_viol), 64'd0);
`else
    a_q = '{32'h0F0F0000, 32'd0};
    b_q = '{32'h000000F0, 32'd0};
    run_cmd(3'b111, 2, 1'b0, 32'd0, 0);
`endif

    // randomized commands
    for (int t = 0; t < 14; t++) begin
      logic [2:0]  op;
      int          len;
      logic        sc;
      logic [31:0] bb;
      op = 3'($urandom_range(0, 7));
      len = $urandom_range(0, 10);
      sc = 1'($urandom_range(0, 1));
      bb = $urandom;
      bp_mode = $urandom_range(0, 2);
      a_q.delete(); b_q.delete();
      for (int i = 0; i < len; i++) begin
        a_q.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
        b_q.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
      end
      run_cmd(op, len, sc, bb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
